mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and the default timeout.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory bus, with a BUSY timeout.
// Optional macro ARB_ROUND_ROBIN_EN: alternate priority; otherwise data always beats fetch.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_read_req,
    input  logic [31:0] if_read_addr,
    output logic        if_read_ack,
    output logic [31:0] if_read_data,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    localparam logic [7:0] TMO_CNT = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        if_ack_q, if_ack_d;
    logic [31:0] if_data_q, if_data_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] d_data_q, d_data_d;
    logic        bus_err_q, bus_err_d;
    logic        grant_data;
    logic        busy_done;
    logic [31:0] read_word;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when fetch should win the next simultaneous request.
    logic fav_fetch_q, fav_fetch_d;
    assign grant_data = d_req && (!if_read_req || !fav_fetch_q);
`else
    assign grant_data = d_req;
`endif

    // A ready arriving on the timeout cycle still counts as a successful access.
    assign busy_done = mem_ready || (cnt_q == TMO_CNT);
    assign read_word = mem_ready ? mem_rdata : 32'h0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        if_data_d   = if_data_q;
        d_ack_d     = 1'b0;
        d_data_d    = d_data_q;
        bus_err_d   = bus_err_q;
`ifdef ARB_ROUND_ROBIN_EN
        fav_fetch_d = fav_fetch_q;
`endif
        case (state_q)
            IDLE: begin
                if (d_req || if_read_req) begin
                    mem_req_d = 1'b1;
                    cnt_d     = 8'd0;
                    if (grant_data) begin
                        state_d     = BUSY_D;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        state_d     = BUSY_I;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_read_addr;
                        mem_wdata_d = 32'h0;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    fav_fetch_d = grant_data;
`endif
                end
            end
            BUSY_I, BUSY_D: begin
                if (busy_done) begin
                    state_d   = ACK;
                    mem_req_d = 1'b0;
                    if (!mem_ready) begin
                        bus_err_d = 1'b1;
                    end
                    if (state_q == BUSY_D) begin
                        d_ack_d  = 1'b1;
                        d_data_d = mem_we_q ? 32'h0 : read_word;
                    end else begin
                        if_ack_d  = 1'b1;
                        if_data_d = read_word;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            if_ack_q    <= 1'b0;
            if_data_q   <= 32'h0;
            d_ack_q     <= 1'b0;
            d_data_q    <= 32'h0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            if_data_q   <= if_data_d;
            d_ack_q     <= d_ack_d;
            d_data_q    <= d_data_d;
            bus_err_q   <= bus_err_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fav_fetch_q <= 1'b0;
        end else begin
            fav_fetch_q <= fav_fetch_d;
        end
    end
`endif

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign if_read_ack  = if_ack_q;
    assign if_read_data = if_data_q;
    assign d_ack        = d_ack_q;
    assign d_rdata      = d_data_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, arbitration, timeout, reset and random traffic.
module tb_mem_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_read_req;
    logic [31:0] if_read_addr;
    logic        if_read_ack;
    logic [31:0] if_read_data;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bus_err;

    mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_read_req  (if_read_req),
        .if_read_addr (if_read_addr),
        .if_read_ack  (if_read_ack),
        .if_read_data (if_read_data),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int txn_no = 0;

    // Reference model state: sticky error and which port wins a tie.
    bit model_err = 1'b0;
    bit fav_data  = 1'b1;

    typedef struct {
        bit          rq_i;
        bit          rq_d;
        bit          we;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] wd;
        int          delay;
        logic [31:0] rdata;
        int          exp_cyc;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tab[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Serve one grant starting in an IDLE cycle with requests already driven.
    task automatic serve(input int delay, input logic [31:0] rdata, input bit use_tab,
                         input int tab_cyc, input logic [31:0] tab_data);
        bit          gd, tmo, got;
        int          cyc, busy, e_cyc;
        logic        e_we;
        logic [31:0] e_addr, e_wdata, e_data, a_data;
        gd = d_req && (!if_read_req || fav_data);
`ifdef ARB_ROUND_ROBIN_EN
        fav_data = !gd;
`endif
        e_addr  = gd ? d_addr : if_read_addr;
        e_we    = gd ? d_we : 1'b0;
        e_wdata = gd ? d_wdata : 32'h0;
        tmo     = (delay + 1 > TMO);
        e_cyc   = tmo ? TMO + 2 : delay + 3;
        e_data  = (tmo || (gd && d_we)) ? 32'h0 : rdata;
        if (use_tab) begin
            e_cyc  = tab_cyc;
            e_data = tab_data;
        end
        model_err = model_err | tmo;
        cyc = 1; busy = 0; got = 1'b0; a_data = 32'h0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_req) begin
                busy++;
                if (busy == 1) begin
                    chk("mem_addr", mem_addr, e_addr);
                    chk("mem_we", 32'(mem_we), 32'(e_we));
                    chk("mem_wdata", mem_wdata, e_wdata);
                    if (gd) begin
                        d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom);
                    end else begin
                        if_read_addr = $urandom;
                    end
                end
                mem_ready = (busy == delay + 1);
                mem_rdata = mem_ready ? rdata : $urandom;
            end else begin
                mem_ready = 1'b0;
            end
            if (if_read_ack || d_ack) begin
                got = 1'b1;
                a_data = gd ? d_rdata : if_read_data;
                chk("ack_port", 32'(d_ack), 32'(gd));
                chk("ack_both", 32'(if_read_ack & d_ack), 32'h0);
                chk("ack_cycle", cyc, e_cyc);
                chk("ack_data", a_data, e_data);
                chk("bus_err", 32'(bus_err), 32'(model_err));
                chk("req_drop", 32'(mem_req), 32'h0);
                if (gd) d_req = 1'b0; else if_read_req = 1'b0;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL ack_wait actual=none required=ack within 40 cycles");
        end
        chk("busy_cycles", busy, tmo ? TMO : delay + 1);
        @(negedge clk);
        mem_ready = 1'b0;
        chk("ack_pulse", {30'h0, if_read_ack, d_ack}, 32'h0);
        txn_no++;
        $display("txn %0d port=%s addr=%h delay=%0d cyc=%0d data=%h err=%0b",
                 txn_no, gd ? "data " : "fetch", e_addr, delay, cyc, a_data, bus_err);
    endtask

    task automatic drive(input bit rq_i, input bit rq_d, input bit we, input logic [31:0] ia,
                         input logic [31:0] da, input logic [31:0] wd);
        if_read_req = rq_i; if_read_addr = ia;
        d_req = rq_d; d_we = we; d_addr = da; d_wdata = wd;
    endtask

    initial begin
        tab[0] = '{1, 0, 0, 32'h10,  32'h0,   32'h0,  0, 32'hDEADBEEF, 3, 32'hDEADBEEF};
        tab[1] = '{0, 1, 1, 32'h0,   32'h100, 32'h55, 0, 32'h12345678, 3, 32'h0};
        tab[2] = '{0, 1, 0, 32'h0,   32'h200, 32'h0,  2, 32'hCAFEF00D, 5, 32'hCAFEF00D};
        tab[3] = '{1, 0, 0, 32'h44,  32'h0,   32'h0,  3, 32'hA5A5A5A5, 6, 32'hA5A5A5A5};

        reset = 1'b1; mem_ready = 1'b0; mem_rdata = 32'h0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_acks", {30'h0, if_read_ack, d_ack}, 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            drive(tab[i].rq_i, tab[i].rq_d, tab[i].we, tab[i].ia, tab[i].da, tab[i].wd);
            serve(tab[i].delay, tab[i].rdata, 1'b1, tab[i].exp_cyc, tab[i].exp_data);
        end
        chk("no_err_after_ready_on_timeout", 32'(bus_err), 32'h0);

        // Simultaneous pair, then a lone data grant, then another pair.
        drive(1, 1, 0, 32'h80, 32'h90, 32'h0);
        serve(0, 32'h11111111, 1'b0, 0, 0);
        serve(1, 32'h22222222, 1'b0, 0, 0);
        drive(0, 1, 1, 32'h0, 32'h94, 32'h77);
        serve(0, 32'h0, 1'b0, 0, 0);
        drive(1, 1, 0, 32'h84, 32'h98, 32'h0);
        serve(0, 32'h33333333, 1'b0, 0, 0);
        serve(0, 32'h44444444, 1'b0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            int sel;
            sel = $urandom_range(1, 3);
            drive(sel[0], sel[1], 1'($urandom), $urandom, $urandom, $urandom);
            while (if_read_req || d_req)
                serve($urandom_range(0, 5), $urandom, 1'b0, 0, 0);
        end

        // Explicit timeout, then a normal access showing the flag stays set.
        drive(1, 0, 0, 32'hF0, 32'h0, 32'h0);
        serve(10, 32'h99999999, 1'b1, TMO + 2, 32'h0);
        chk("err_sticky", 32'(bus_err), 32'h1);
        drive(0, 1, 0, 32'h0, 32'hA0, 32'h0);
        serve(0, 32'h13572468, 1'b0, 0, 0);

        // Reset in the middle of a data access.
        drive(0, 1, 0, 32'h0, 32'h300, 32'h0);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(mem_req), 32'h1);
        reset = 1'b1; d_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_err = 1'b0; fav_data = 1'b1;
        chk("midrst_mem_req", 32'(mem_req), 32'h0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_bus_err", 32'(bus_err), 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("midrst_quiet", {29'h0, mem_req, if_read_ack, d_ack}, 32'h0);
        end
        drive(1, 1, 0, 32'hB0, 32'hC0, 32'h0);
        serve(0, 32'h2468ACE0, 1'b0, 0, 0);
        serve(0, 32'h0F0F0F0F, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
